// File: rtl/btn_event_hold_pkg.sv
// Shared game timing constants and pending-queue action codes
// for the button event path.
package btn_event_hold_pkg;

  localparam int PRESC_W_DEF    = 17;
  localparam int HOLD_TICKS_DEF = 8;
  localparam int HOLD_W_DEF     = 4;
  localparam int MAX_PEND_DEF   = 3;
  localparam int CNT_W_DEF      = 2;

  typedef enum logic [1:0] {
    PEND_KEEP,
    PEND_INC,
    PEND_DEC,
    PEND_DROP
  } pend_op_e;

endpackage

// File: rtl/btn_event_hold_tick_gen.sv
// Free-running prescaler; tick is high for the one cycle
// the counter sits at all-ones.
module tick_gen
  import btn_event_hold_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [PRESC_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

  assign tick = &cnt;

endmodule

// File: rtl/btn_event_hold.sv
// Press strobes -> saturating pending count with req/ack
// handshake, plus a tick-timed stretched LED level.
module btn_event_hold
  import btn_event_hold_pkg::*;
#(
  parameter int PRESC_W    = PRESC_W_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF,
  parameter int HOLD_W     = HOLD_W_DEF,
  parameter int MAX_PEND   = MAX_PEND_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_i,
  input  logic             evt_ack,
  input  logic             ovf_clr,
  output logic             evt_req,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf,
  output logic             led_o
);

  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_PEND);
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_TICKS);

  logic              tick;
  logic              acc;
  logic              full;
  logic [HOLD_W-1:0] hold;
  pend_op_e          op;

  tick_gen #(.PRESC_W(PRESC_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // an ack only counts while something is actually pending
  assign acc  = evt_ack & evt_req;
  assign full = (evt_cnt >= MAX_CNT);

  always_comb begin
    op = PEND_KEEP;
    unique case (1'b1)
      evt_i & ~acc & ~full: op = PEND_INC;
      evt_i & ~acc &  full: op = PEND_DROP;
      acc & ~evt_i:         op = PEND_DEC;
      default:              op = PEND_KEEP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      unique case (op)
        PEND_INC:  evt_cnt <= evt_cnt + 1'b1;
        PEND_DEC:  evt_cnt <= evt_cnt - 1'b1;
        default:   evt_cnt <= evt_cnt;
      endcase
      if (op == PEND_DROP) ovf <= 1'b1;
      else if (ovf_clr)    ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    hold <= '0;
    else if (evt_i)             hold <= HOLD_LD;
    else if (tick && hold != 0) hold <= hold - 1'b1;
  end

  assign evt_req = (evt_cnt != '0);
  assign led_o   = (hold != '0);

endmodule
